// File: rtl/xip_cache_core.sv
// Execute-in-place read cache in front of a flash controller.
// Direct-mapped and read-allocate. Writes are forwarded to flash as
// program, sector-erase or quad-enable ops, and every completed write
// invalidates the whole cache.
module xip_cache_core #(
    parameter int LINE_WORDS = 4,
    parameter int NUM_LINES  = 8
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic        gnt_o,
    output logic        rvalid_o,
    output logic [31:0] data_o,
    input  logic        flush_i,
    output logic        mem_req_o,
    output logic [1:0]  mem_op_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_valid_i,
    input  logic [31:0] mem_rdata_i
);

    localparam int OW  = $clog2(LINE_WORDS);
    localparam int IW  = $clog2(NUM_LINES);
    localparam int IWS = (IW > 0) ? IW : 1;
    localparam int TW  = 20 - OW - IW;

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_WRITE} state_e;

    typedef struct packed {
        logic [TW-1:0]  tag;
        logic [IWS-1:0] idx;
        logic [OW-1:0]  off;
    } lookup_t;

    state_e          state_q;
    logic [NUM_LINES-1:0] valid_q;
    logic [TW-1:0]   tag_q  [NUM_LINES];
    logic [31:0]     data_q [NUM_LINES][LINE_WORDS];
    logic [OW-1:0]   cnt_q;
    logic            flush_q;
    lookup_t         req_q;
    logic [31:0]     line_base_q;

    lookup_t         lk;
    logic [1:0]      op;
    logic            hit;
    logic            fill_beat;
    logic            fill_last;
    logic            unused_ok;

    // Byte enables and the upper address byte do not affect flash behaviour.
    assign unused_ok = ^{be_i, addr_i[31:24], addr_i[1:0]};

    // Address split and write-op decode for the incoming request.
    always_comb begin
        lk     = '0;
        lk.off = addr_i[2 +: OW];
        lk.idx = IWS'((addr_i[21:0] >> (2 + OW)) & 22'(NUM_LINES - 1));
        lk.tag = TW'(addr_i[21:0] >> (2 + OW + IW));
        op     = 2'b00;
        if (we_i) begin
            if (addr_i[23:22] == 2'b11)      op = 2'b11;
            else if (addr_i[23:22] == 2'b10) op = 2'b10;
            else                             op = 2'b01;
        end
    end

    // A flush in the same cycle takes effect before the lookup, so it forces a miss.
    assign hit       = valid_q[lk.idx] & (tag_q[lk.idx] == lk.tag) & ~flush_i;
    assign gnt_o     = req_i & (state_q == S_IDLE);
    assign fill_beat = (state_q == S_FILL) & mem_req_o & mem_valid_i;
    assign fill_last = (cnt_q == OW'(LINE_WORDS - 1));

    // Line storage is not reset; the valid bits decide whether it is used.
    always_ff @(posedge clk_i) begin
        if (fill_beat) begin
            data_q[req_q.idx][cnt_q] <= mem_rdata_i;
            if (fill_last) tag_q[req_q.idx] <= req_q.tag;
        end
    end

    // Control FSM, flash request and OBI response registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            valid_q     <= '0;
            cnt_q       <= '0;
            flush_q     <= 1'b0;
            req_q       <= '0;
            line_base_q <= '0;
            rvalid_o    <= 1'b0;
            data_o      <= '0;
            mem_req_o   <= 1'b0;
            mem_op_o    <= '0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
        end else begin
            rvalid_o <= 1'b0;
            data_o   <= '0;
            case (state_q)
                S_IDLE: begin
                    if (flush_i) valid_q <= '0;
                    if (gnt_o) begin
                        if (we_i) begin
                            state_q     <= S_WRITE;
                            mem_req_o   <= 1'b1;
                            mem_op_o    <= op;
                            mem_addr_o  <= {10'h0, addr_i[21:0]};
                            mem_wdata_o <= data_i;
                        end else if (hit) begin
                            rvalid_o <= 1'b1;
                            data_o   <= data_q[lk.idx][lk.off];
                        end else begin
                            state_q     <= S_FILL;
                            cnt_q       <= '0;
                            flush_q     <= 1'b0;
                            req_q       <= lk;
                            line_base_q <= {10'h0, addr_i[21:2+OW], {(OW+2){1'b0}}};
                            mem_req_o   <= 1'b1;
                            mem_op_o    <= 2'b00;
                            mem_addr_o  <= {10'h0, addr_i[21:2+OW], {(OW+2){1'b0}}};
                        end
                    end
                end
                S_FILL: begin
                    if (flush_i) flush_q <= 1'b1;
                    if (mem_req_o && mem_valid_i) begin
                        mem_req_o <= 1'b0;
                        cnt_q     <= cnt_q + 1'b1;
                        if (fill_last) begin
                            state_q  <= S_IDLE;
                            rvalid_o <= 1'b1;
                            // The requested word may be the one arriving right now.
                            data_o   <= (req_q.off == cnt_q) ? mem_rdata_i
                                                             : data_q[req_q.idx][req_q.off];
                            flush_q  <= 1'b0;
                            if (flush_q || flush_i) valid_q <= '0;
                            else                    valid_q[req_q.idx] <= 1'b1;
                        end
                    end else if (!mem_req_o) begin
                        // One idle cycle after each beat, then fetch the next word.
                        mem_req_o  <= 1'b1;
                        mem_addr_o <= line_base_q + {{(30-OW){1'b0}}, cnt_q, 2'b00};
                    end
                end
                S_WRITE: begin
                    if (mem_req_o && mem_valid_i) begin
                        mem_req_o <= 1'b0;
                        valid_q   <= '0;
                        rvalid_o  <= 1'b1;
                        state_q   <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_xip_cache_core.sv
// Scoreboard bench for xip_cache_core: stimulus pushes expected flash requests
// and expected read data; a flash model and a response monitor pop and compare.
module tb_xip_cache_core;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        req_i, we_i, flush_i, mem_valid_i;
    logic [3:0]  be_i;
    logic [31:0] addr_i, data_i, mem_rdata_i;
    logic        gnt_o, rvalid_o, mem_req_o;
    logic [31:0] data_o, mem_addr_o, mem_wdata_o;
    logic [1:0]  mem_op_o;

    always #5 clk_i = ~clk_i;

    xip_cache_core #(.LINE_WORDS(4), .NUM_LINES(8)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_i(req_i), .we_i(we_i), .be_i(be_i), .addr_i(addr_i), .data_i(data_i),
        .gnt_o(gnt_o), .rvalid_o(rvalid_o), .data_o(data_o),
        .flush_i(flush_i),
        .mem_req_o(mem_req_o), .mem_op_o(mem_op_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o),
        .mem_valid_i(mem_valid_i), .mem_rdata_i(mem_rdata_i)
    );

    typedef struct packed {
        logic [1:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mreq_t;

    mreq_t       mq[$];
    logic [31:0] rq[$];
    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;
    int beats  = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", name, got, exp);
        end
    endtask

    // Flash model: word content is derived from its address.
    initial begin
        mreq_t cur;
        mreq_t e;
        int    wait_n;
        int    lat_sel;
        bit    pending;
        cur = '0; wait_n = 0; lat_sel = 0; pending = 1'b0;
        mem_valid_i = 1'b0;
        mem_rdata_i = '0;
        forever begin
            @(negedge clk_i);
            if (!mon_en) begin
                mem_valid_i = 1'b0;
                pending     = 1'b0;
            end else if (mem_valid_i) begin
                mem_valid_i = 1'b0;
                mem_rdata_i = '0;
                pending     = 1'b0;
                chk("mem_gap", 32'(mem_req_o), 32'h0);
            end else if (mem_req_o) begin
                if (!pending) begin
                    pending = 1'b1;
                    wait_n  = lat_sel % 3;
                    lat_sel++;
                    cur = '{mem_op_o, mem_addr_o, mem_wdata_o};
                    if (mq.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL mem_unexpected got addr %h op %b exp none", mem_addr_o, mem_op_o);
                    end else begin
                        e = mq.pop_front();
                        chk("mem_op", 32'(mem_op_o), 32'(e.op));
                        chk("mem_addr", mem_addr_o, e.addr);
                        if (e.op != 2'b00) chk("mem_wdata", mem_wdata_o, e.wdata);
                    end
                end else begin
                    chk("mem_hold_addr", mem_addr_o, cur.addr);
                    chk("mem_hold_op", 32'(mem_op_o), 32'(cur.op));
                end
                if (wait_n == 0) begin
                    mem_valid_i = 1'b1;
                    mem_rdata_i = {16'hF1A5, mem_addr_o[15:0]};
                    beats++;
                end else begin
                    wait_n--;
                end
            end else begin
                pending = 1'b0;
            end
        end
    end

    // Response monitor: every rvalid pops the oldest expected word.
    always @(negedge clk_i) begin
        if (mon_en) begin
            if (rvalid_o) begin
                if (rq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rvalid_unexpected got %h exp none", data_o);
                end else begin
                    chk("rdata", data_o, rq.pop_front());
                end
            end else begin
                chk("data_idle", data_o, 32'h0);
            end
        end
    end

    task automatic push_fill(input logic [31:0] base);
        for (int i = 0; i < 4; i++) mq.push_back(mreq_t'{2'b00, base + 32'(4 * i), 32'h0});
    endtask

    task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] d);
        int n;
        n = 0;
        req_i = 1'b1; we_i = we; addr_i = a; data_i = d; be_i = 4'hF;
        forever begin
            @(negedge clk_i);
            if (gnt_o) break;
            n++;
            if (n > 300) begin
                checks++; errors++;
                $display("FAIL gnt_timeout got no grant exp grant addr %h", a);
                break;
            end
        end
        @(posedge clk_i); #1;
        req_i = 1'b0; we_i = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((rq.size() != 0 || mq.size() != 0) && n < 500) begin
            @(posedge clk_i);
            n++;
        end
        chk("idle_timeout", 32'(n >= 500), 32'h0);
        @(posedge clk_i); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got running exp finished");
        $fatal(1);
    end

    initial begin
        int b0;
        int n;
        rst_ni = 1'b0; req_i = 1'b0; we_i = 1'b0; be_i = 4'h0;
        addr_i = '0; data_i = '0; flush_i = 1'b0;

        // Reset state
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_rvalid", 32'(rvalid_o), 32'h0);
        chk("rst_data", data_o, 32'h0);
        chk("rst_memreq", 32'(mem_req_o), 32'h0);
        chk("rst_memop", 32'(mem_op_o), 32'h0);
        chk("rst_memaddr", mem_addr_o, 32'h0);
        chk("rst_memwdata", mem_wdata_o, 32'h0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        mon_en = 1'b1;

        // Cold read fills line 0 and returns word 2
        push_fill(32'h0); rq.push_back(32'hF1A50008);
        issue(1'b0, 32'h2000_0008, 32'h0); wait_idle();

        // Hit: rvalid the cycle after grant, no flash traffic
        rq.push_back(32'hF1A50004);
        issue(1'b0, 32'h2000_0004, 32'h0);
        @(negedge clk_i);
        chk("hit_latency", 32'(rvalid_o), 32'h1);
        wait_idle();

        // Flush in the grant cycle forces a miss
        push_fill(32'h0); rq.push_back(32'hF1A5000C);
        flush_i = 1'b1;
        issue(1'b0, 32'h2000_000C, 32'h0);
        flush_i = 1'b0;
        wait_idle();

        // Back-to-back hits: next grant in the rvalid cycle
        rq.push_back(32'hF1A50004); rq.push_back(32'hF1A50008);
        issue(1'b0, 32'h4, 32'h0);
        chk("b2b_rvalid", 32'(rvalid_o), 32'h1);
        req_i = 1'b1; addr_i = 32'h8;
        @(negedge clk_i);
        chk("b2b_gnt", 32'(gnt_o & rvalid_o), 32'h1);
        @(posedge clk_i); #1;
        req_i = 1'b0;
        wait_idle();

        // Idle flush, then conflicting lines on index 0 all miss
        flush_i = 1'b1;
        @(posedge clk_i); #1;
        flush_i = 1'b0;
        push_fill(32'h0);  rq.push_back(32'hF1A50000); issue(1'b0, 32'h0,  32'h0); wait_idle();
        push_fill(32'h80); rq.push_back(32'hF1A50080); issue(1'b0, 32'h80, 32'h0); wait_idle();
        push_fill(32'h0);  rq.push_back(32'hF1A50000); issue(1'b0, 32'h0,  32'h0); wait_idle();

        // Program write, then the cached line is gone
        mq.push_back(mreq_t'{2'b01, 32'h100, 32'hDEADBEEF}); rq.push_back(32'h0);
        issue(1'b1, 32'h0000_0100, 32'hDEADBEEF); wait_idle();
        push_fill(32'h0); rq.push_back(32'hF1A50000); issue(1'b0, 32'h0, 32'h0); wait_idle();

        // Sector erase and quad enable decode
        mq.push_back(mreq_t'{2'b10, 32'h1000, 32'h11}); rq.push_back(32'h0);
        issue(1'b1, 32'h0080_1000, 32'h11); wait_idle();
        mq.push_back(mreq_t'{2'b11, 32'h0, 32'h22}); rq.push_back(32'h0);
        issue(1'b1, 32'h00C0_0000, 32'h22); wait_idle();

        // Flush during a fill: data still returned, line left invalid
        push_fill(32'h40); rq.push_back(32'hF1A50040);
        issue(1'b0, 32'h40, 32'h0);
        repeat (3) @(posedge clk_i);
        #1 flush_i = 1'b1;
        @(posedge clk_i); #1;
        flush_i = 1'b0;
        wait_idle();
        push_fill(32'h40); rq.push_back(32'hF1A50040); issue(1'b0, 32'h40, 32'h0); wait_idle();

        // Reset after the second fill beat abandons the read
        b0 = beats;
        mq.push_back(mreq_t'{2'b00, 32'h200, 32'h0});
        mq.push_back(mreq_t'{2'b00, 32'h204, 32'h0});
        issue(1'b0, 32'h204, 32'h0);
        n = 0;
        while (beats < b0 + 2 && n < 200) begin
            @(posedge clk_i);
            n++;
        end
        chk("beat_timeout", 32'(n >= 200), 32'h0);
        #1 rst_ni = 1'b0;
        @(negedge clk_i);
        @(posedge clk_i);
        @(negedge clk_i);
        chk("midfill_rst_memreq", 32'(mem_req_o), 32'h0);
        chk("midfill_rst_rvalid", 32'(rvalid_o), 32'h0);
        chk("midfill_rst_reqs_left", 32'(mq.size()), 32'h0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        push_fill(32'h200); rq.push_back(32'hF1A50204);
        issue(1'b0, 32'h204, 32'h0); wait_idle();

        repeat (3) @(posedge clk_i);
        chk("end_rq_empty", 32'(rq.size()), 32'h0);
        chk("end_mq_empty", 32'(mq.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/xip_cache_core.md
XIP_CACHE_CORE -- requirements
Module: xip_cache_core

Interface
REQ-001 The block SHALL have parameter LINE_WORDS, default 4, meaning 32-bit words per cache line (power of 2, 2..16).
REQ-002 The block SHALL have parameter NUM_LINES, default 8, meaning direct-mapped lines (power of 2, 1..64).
REQ-003 The block SHALL have ports clk_i, input, 1, the single clock; all logic on its rising edge.
REQ-004 The block SHALL have ports rst_ni, input, 1, reset, synchronous and active-low.
REQ-005 The block SHALL have ports req_i in 1, we_i in 1, be_i in 4, addr_i in 32 and data_i in 32, forming the OBI request; be_i is ignored.
REQ-006 The block SHALL have ports gnt_o out 1, rvalid_o out 1 and data_o out 32, forming the OBI response.
REQ-007 The block SHALL have port flush_i, input, 1, meaning invalidate all lines.
REQ-008 The block SHALL have ports mem_req_o out 1, mem_op_o out 2, mem_addr_o out 32 and mem_wdata_o out 32, forming the flash-controller request.
REQ-009 The block SHALL have ports mem_valid_i in 1 and mem_rdata_i in 32, forming the flash-controller completion.

Function
REQ-010 Op decode SHALL be: we_i=0 gives 00 (read); we_i=1 with addr_i[23:22]=11 gives 11 (quad enable), =10 gives 10 (sector erase), otherwise 01 (program).
REQ-011 Addressing SHALL be as follows.
- Flash address is {10'h0, addr_i[21:0]}.
- Word offset is addr_i[2 +: log2(LINE_WORDS)].
- Index is the next log2(NUM_LINES) bits.
- Tag is the remaining bits up to bit 21.
REQ-012 States SHALL be S_IDLE, S_FILL and S_WRITE.
- gnt_o = req_i & (state == S_IDLE).
- gnt_o is combinational and allowed in the same cycle as rvalid_o.
REQ-013 A read hit granted in cycle N SHALL give rvalid_o=1 and data_o=cached word in cycle N+1, with state staying S_IDLE and no mem_req_o.
REQ-014 A read miss SHALL enter S_FILL with fill counter 0.
- The counter selects the flash word address line_base + 4*cnt, with mem_op_o=00.
- Each mem_valid_i stores mem_rdata_i into word cnt and increments cnt.
REQ-015 After the LINE_WORDS-th mem_valid_i, the block SHALL do the following on the next edge.
- Set the line valid and tag.
- Drive rvalid_o=1 with the requested word.
- Return to S_IDLE.
REQ-016 A granted write-type op (01/10/11) SHALL enter S_WRITE with mem_op_o = decoded op, mem_addr_o = flash address and mem_wdata_o = data_i.
- On mem_valid_i: all lines invalidated, rvalid_o=1 next cycle, data_o=0, return to S_IDLE.
REQ-017 mem_req_o handshake SHALL follow these rules.
- mem_req_o, mem_op_o, mem_addr_o and mem_wdata_o are held stable from assertion until mem_valid_i.
- mem_req_o is low in the cycle after every mem_valid_i, giving a one-cycle gap between fill words.
- mem_valid_i while mem_req_o=0 is ignored.
REQ-018 rvalid_o SHALL be a single-cycle pulse per granted request; responses are in order; data_o is 0 whenever rvalid_o=0.
REQ-019 flush_i in S_IDLE SHALL clear all valid bits at that edge.
- If a read is granted in the same cycle, the lookup sees the flushed state and misses.
REQ-020 flush_i asserted any cycle during S_FILL SHALL be latched.
- The fill completes and returns data.
- The line is left invalid and the latch clears on return to S_IDLE.
REQ-021 flush_i during S_WRITE SHALL have no extra effect, since the cache is invalidated on completion anyway.
REQ-022 Back-to-back: a request SHALL be grantable in the cycle rvalid_o of the previous one is high.

Reset
REQ-023 While rst_ni=0 at a clock edge, the following SHALL hold.
- state goes to S_IDLE.
- All valid bits are cleared, along with the fill counter and flush latch.
- rvalid_o=0, data_o=0, mem_req_o=0, mem_op_o=0, mem_addr_o=0, mem_wdata_o=0.
REQ-024 Tag and data arrays SHALL be non-reset.
REQ-025 Reset mid-fill or mid-write SHALL abandon the operation with no rvalid_o; the line is left invalid.

Verification (LINE_WORDS=4, NUM_LINES=8)
REQ-026 Cold read 0x2000_0008 SHALL produce mem reads at 0x0, 0x4, 0x8 and 0xC, with rvalid_o carrying word 0x8.
- A following read of 0x2000_0004 then hits, with rvalid_o one cycle after gnt_o and no mem_req_o.
REQ-027 Reads 0x0 then 0x80 (same index 0) SHALL both miss and refill, and a re-read of 0x0 SHALL miss again.
REQ-028 A write of 0xDEADBEEF to 0x0000_0100 after caching 0x0 SHALL give the following.
- mem_op_o=01, mem_addr_o=0x100, mem_wdata_o=0xDEADBEEF.
- A subsequent read of 0x0 misses.
REQ-029 A write to 0x0080_1000 SHALL give mem_op_o=10 and mem_addr_o=0x0000_1000; a write to 0x00C0_0000 SHALL give mem_op_o=11.
REQ-030 flush_i pulsed during the fill of 0x40 SHALL still return the correct word, and a re-read of 0x40 SHALL miss.
REQ-031 rst_ni=0 after the 2nd fill word SHALL give mem_req_o=0 and no rvalid_o, and a read of the same address SHALL then miss with a full 4-word refill.
